// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks.
//   rx_state_t  : receiver FSM state encoding
//   PARITY_*    : parity mode codes, shared with the configurable transmitter
//   maj3        : 3-input majority vote used for bit sampling
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Handshake bundle between the baud tick generator / serial line / consumer
// and the configurable UART receiver.
//   master : drives i_tick, i_rx, i_rd; observes received word and status
//   slave  : the receiver side
interface uart_rx_cfg_if #(
  parameter int NBITS = 8
);
  logic             i_tick;
  logic             i_rx;
  logic             i_rd;
  logic [NBITS-1:0] o_data;
  logic             o_valid;
  logic             o_rx_done;
  logic             o_parity_err;
  logic             o_frame_err;
  logic             o_break;
  logic             o_overrun;

  modport master (
    output i_tick, i_rx, i_rd,
    input  o_data, o_valid, o_rx_done, o_parity_err, o_frame_err, o_break, o_overrun
  );

  modport slave (
    input  i_tick, i_rx, i_rd,
    output o_data, o_valid, o_rx_done, o_parity_err, o_frame_err, o_break, o_overrun
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk   : destination clock
//   rst   : asynchronous active-low reset, loads RST_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output (two clocks of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: NBITS data bits, OVERSAMPLE ticks per bit,
// optional even/odd parity, 1 or 2 stop bits, 3-sample majority vote.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of uart_rx_cfg_if (tick, line, read strobe in;
//              word, valid, done pulse, parity/frame/break/overrun out)
//
// state      | meaning
// IDLE       | line idle, waiting for a low level
// START      | validating start bit; high vote at mid-bit rejects it
// DATA       | shifting in NBITS data bits, LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling stop bit(s); frame completes at last stop vote
// WAIT_HIGH  | framing error seen, hold off until the line returns high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NBITS       = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_cfg_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] T_V0  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] T_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] T_V2  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] T_END = CW'(OVERSAMPLE - 1);

  rx_state_t        state, state_nxt;
  logic [CW-1:0]    tick_cnt;
  logic [3:0]       bit_cnt;
  logic [NBITS-1:0] shreg;
  logic             rxs, v0, v1, par_bit, ferr_acc;
  logic             active, vote_pt, bit_end, voted, frame_end;
  logic             frame_ferr, exp_par, perr_nxt, brk_nxt;

  logic [NBITS-1:0] data_q;
  logic             valid_q, done_q, perr_q, ferr_q, brk_q, ovr_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.i_rx),
    .q   (rxs)
  );

  assign active    = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign vote_pt   = active && bus.i_tick && (tick_cnt == T_V2);
  assign bit_end   = active && bus.i_tick && (tick_cnt == T_END);
  // Third sample is taken live at the last vote tick.
  assign voted     = maj3(v0, v1, rxs);
  assign frame_end = (state == ST_STOP) && vote_pt && (bit_cnt == 4'(STOP_BITS - 1));

  assign frame_ferr = ferr_acc | ~voted;
  assign exp_par    = (PARITY_MODE == PARITY_ODD) ? ~^shreg : ^shreg;
  assign perr_nxt   = (PARITY_MODE != PARITY_NONE) && (par_bit != exp_par);
  assign brk_nxt    = frame_ferr && (shreg == '0) &&
                      ((PARITY_MODE == PARITY_NONE) || !par_bit);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (!rxs) state_nxt = ST_START;
      ST_START: begin
        if (vote_pt && voted) state_nxt = ST_IDLE;
        else if (bit_end)     state_nxt = ST_DATA;
      end
      ST_DATA:
        if (bit_end && (bit_cnt == 4'(NBITS - 1)))
          state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_end) state_nxt = ST_STOP;
      ST_STOP:      if (frame_end) state_nxt = frame_ferr ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (rxs) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= frame_end;

      if (state == ST_IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        ferr_acc <= 1'b0;
      end else if (active && bus.i_tick) begin
        tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + CW'(1);
        if (tick_cnt == T_V0)  v0 <= rxs;
        if (tick_cnt == T_MID) v1 <= rxs;
      end

      if (vote_pt) begin
        if (state == ST_DATA)   shreg   <= {voted, shreg[NBITS-1:1]};
        if (state == ST_PARITY) par_bit <= voted;
        if (state == ST_STOP && !voted) ferr_acc <= 1'b1;
      end

      // Bit index restarts whenever a bit period moves the FSM to a new field.
      if (bit_end)
        bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;

      // Completion has priority over a coincident read strobe.
      if (frame_end) begin
        data_q  <= shreg;
        perr_q  <= perr_nxt;
        ferr_q  <= frame_ferr;
        brk_q   <= brk_nxt;
        valid_q <= 1'b1;
        ovr_q   <= (ovr_q | valid_q) & ~bus.i_rd;
      end else if (bus.i_rd) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_rx_done    = done_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_break      = brk_q;
  assign bus.o_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers sharing clock/tick/reset.
//   lane 0: 8N1, lane 1: 8E1 (even parity), lane 2: 8N2.
// Frames are driven as bit sequences; expectations come from a frame-level
// model of the received word and status flags.
module tb_uart_rx_cfg;
  localparam int BITCLK = 32;  // 16 ticks per bit, one tick every 2 clocks

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;
  logic rx [3];
  logic rd [3];

  int errors = 0;
  int checks = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic exp_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic exp_ovr   [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(negedge clk) tick = ~tick;

  uart_rx_cfg_if #(.NBITS(8)) b0 ();
  uart_rx_cfg_if #(.NBITS(8)) b1 ();
  uart_rx_cfg_if #(.NBITS(8)) b2 ();

  assign b0.i_tick = tick;
  assign b1.i_tick = tick;
  assign b2.i_tick = tick;
  assign b0.i_rx = rx[0];
  assign b1.i_rx = rx[1];
  assign b2.i_rx = rx[2];
  assign b0.i_rd = rd[0];
  assign b1.i_rd = rd[1];
  assign b2.i_rd = rd[2];

  uart_rx_cfg #(.NBITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  uart_rx_cfg #(.NBITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  uart_rx_cfg #(.NBITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  always @(negedge clk) begin
    if (b0.o_rx_done) done_cnt[0]++;
    if (b1.o_rx_done) done_cnt[1]++;
    if (b2.o_rx_done) done_cnt[2]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {overrun, valid, break, frame_err, parity_err, data[7:0]}
  function automatic logic [12:0] lane_out(input int lane);
    case (lane)
      0: return {b0.o_overrun, b0.o_valid, b0.o_break, b0.o_frame_err, b0.o_parity_err, b0.o_data};
      1: return {b1.o_overrun, b1.o_valid, b1.o_break, b1.o_frame_err, b1.o_parity_err, b1.o_data};
      default: return {b2.o_overrun, b2.o_valid, b2.o_break, b2.o_frame_err, b2.o_parity_err, b2.o_data};
    endcase
  endfunction

  function automatic logic lane_done(input int lane);
    case (lane)
      0: return b0.o_rx_done;
      1: return b1.o_rx_done;
      default: return b2.o_rx_done;
    endcase
  endfunction

  task automatic send_bit(input int lane, input logic b);
    rx[lane] = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic idle(input int lane, input int nbits);
    rx[lane] = 1'b1;
    repeat (nbits * BITCLK) @(negedge clk);
  endtask

  task automatic check_lane(input int lane, input string tag, input logic [7:0] d,
                            input logic pe, input logic fe, input logic bk);
    logic [12:0] o;
    o = lane_out(lane);
    chk($sformatf("%s.l%0d.data", tag, lane),  o[7:0], d);
    chk($sformatf("%s.l%0d.perr", tag, lane),  o[8],   pe);
    chk($sformatf("%s.l%0d.ferr", tag, lane),  o[9],   fe);
    chk($sformatf("%s.l%0d.break", tag, lane), o[10],  bk);
    chk($sformatf("%s.l%0d.valid", tag, lane), o[11],  exp_valid[lane]);
    chk($sformatf("%s.l%0d.ovr", tag, lane),   o[12],  exp_ovr[lane]);
  endtask

  // Lane 1 carries even parity, lane 2 two stop bits.
  task automatic send_frame(input int lane, input string tag, input logic [7:0] d,
                            input logic par, input logic s1, input logic s2);
    int   d0;
    logic has_par, pe, fe, bk;
    d0 = done_cnt[lane];
    has_par = (lane == 1);
    send_bit(lane, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(lane, d[i]);
    if (has_par) send_bit(lane, par);
    send_bit(lane, s1);
    if (lane == 2) send_bit(lane, s2);
    idle(lane, 2);
    pe = has_par && (par != ((^d) ? 1'b1 : 1'b0));
    fe = !s1 || ((lane == 2) && !s2);
    bk = fe && (d == 8'h00) && (!has_par || !par);
    exp_ovr[lane]   = exp_ovr[lane] | exp_valid[lane];
    exp_valid[lane] = 1'b1;
    chk($sformatf("%s.l%0d.done", tag, lane), done_cnt[lane] - d0, 1);
    check_lane(lane, tag, d, pe, fe, bk);
  endtask

  task automatic do_rd(input int lane);
    rd[lane] = 1'b1;
    @(negedge clk);
    rd[lane] = 1'b0;
    @(negedge clk);
    exp_valid[lane] = 1'b0;
    exp_ovr[lane]   = 1'b0;
  endtask

  initial begin
    int d0;
    logic [7:0] rdat;
    logic rpar, rs1, rs2;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1;
      rd[i] = 1'b0;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.l%0d.outs", i), lane_out(i), 13'h0);
      chk($sformatf("reset.l%0d.done", i), lane_done(i), 1'b0);
    end
    rst = 1'b1;
    idle(0, 2);

    // 8N1 basic frames with a read in between
    send_frame(0, "f55", 8'h55, 1'b0, 1'b1, 1'b1);
    do_rd(0);
    chk("rd55.valid", lane_out(0) >> 11, 0);
    send_frame(0, "fA3", 8'hA3, 1'b0, 1'b1, 1'b1);
    do_rd(0);

    // Even parity: 0x07 needs parity 1
    send_frame(1, "p07bad", 8'h07, 1'b0, 1'b1, 1'b1);
    do_rd(1);
    send_frame(1, "p07ok", 8'h07, 1'b1, 1'b1, 1'b1);
    do_rd(1);

    // False start: 4 ticks low
    d0 = done_cnt[0];
    rx[0] = 1'b0;
    repeat (8) @(negedge clk);
    idle(0, 2);
    chk("glitch.done", done_cnt[0] - d0, 0);
    chk("glitch.valid", lane_out(0) >> 11, 0);
    send_frame(0, "f3C", 8'h3C, 1'b0, 1'b1, 1'b1);
    do_rd(0);

    // Framing error and break
    send_frame(0, "ferr81", 8'h81, 1'b0, 1'b0, 1'b1);
    do_rd(0);
    d0 = done_cnt[0];
    rx[0] = 1'b0;
    repeat (20 * BITCLK) @(negedge clk);
    chk("break.done_low", done_cnt[0] - d0, 1);
    idle(0, 2);
    chk("break.done_high", done_cnt[0] - d0, 1);
    exp_valid[0] = 1'b1;
    check_lane(0, "break", 8'h00, 1'b0, 1'b1, 1'b1);
    do_rd(0);
    send_frame(0, "postbrk", 8'hC5, 1'b0, 1'b1, 1'b1);
    do_rd(0);

    // Overrun
    send_frame(0, "o11", 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, "o22", 8'h22, 1'b0, 1'b1, 1'b1);
    do_rd(0);
    chk("ovr_rd.flags", lane_out(0) >> 11, 0);

    // Two stop bits, second low
    send_frame(2, "s2bad", 8'h5A, 1'b0, 1'b1, 1'b0);
    do_rd(2);
    send_frame(2, "s2ok", 8'hE7, 1'b0, 1'b1, 1'b1);
    do_rd(2);

    // Randomized frames against the frame-level model
    for (int n = 0; n < 6; n++) begin
      rdat = 8'($urandom_range(0, 255));
      send_frame(0, "rnd0", rdat, 1'b0, 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 1) do_rd(0);
    end
    for (int n = 0; n < 6; n++) begin
      rdat = 8'($urandom_range(0, 255));
      rpar = 1'($urandom_range(0, 1));
      send_frame(1, "rnd1", rdat, rpar, 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 1) do_rd(1);
    end
    for (int n = 0; n < 5; n++) begin
      rdat = (n == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rs1  = 1'($urandom_range(0, 1));
      rs2  = 1'($urandom_range(0, 1));
      send_frame(2, "rnd2", rdat, 1'b0, rs1, rs2);
      if ($urandom_range(0, 1) == 1) do_rd(2);
    end

    // Reset in the middle of DATA
    d0 = done_cnt[0];
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    rx[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.outs", lane_out(0), 13'h0);
    chk("midrst.done", lane_done(0), 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_valid[i] = 1'b0;
      exp_ovr[i]   = 1'b0;
    end
    idle(0, 12);
    chk("midrst.nodone", done_cnt[0] - d0, 0);
    chk("midrst.after", lane_out(0), 13'h0);
    send_frame(0, "postrst", 8'h96, 1'b0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
